// File: rtl/clock_set_ctrl_pkg.sv
// Shared encodings for the clock time-setting controller: press codes,
// FSM states, field-select values and field limits.
package clock_set_ctrl_pkg;

  localparam logic [1:0] BTN_NONE  = 2'b00;
  localparam logic [1:0] BTN_SHORT = 2'b01;
  localparam logic [1:0] BTN_LONG  = 2'b10;

  localparam logic [1:0] FSEL_NONE = 2'b00;
  localparam logic [1:0] FSEL_HOUR = 2'b01;
  localparam logic [1:0] FSEL_MIN  = 2'b10;
  localparam logic [1:0] FSEL_SEC  = 2'b11;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MS_MAX   = 6'd59;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SET_H,
    ST_SET_M,
    ST_SET_S
  } state_t;

  function automatic logic [1:0] fsel_of(state_t s);
    case (s)
      ST_SET_H: return FSEL_HOUR;
      ST_SET_M: return FSEL_MIN;
      ST_SET_S: return FSEL_SEC;
      default:  return FSEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_event.sv
// Turns a level-held press code into one-cycle short/long event pulses,
// firing only on the 00 -> 01/10 transition; events are combinational off the current code.
module btn_event
  import clock_set_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_code,
  output logic       o_short_ev,
  output logic       o_long_ev
);

  logic [1:0] r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_prev <= BTN_NONE;
    else          r_prev <= i_code;
  end

  assign o_short_ev = (r_prev == BTN_NONE) && (i_code == BTN_SHORT);
  assign o_long_ev  = (r_prev == BTN_NONE) && (i_code == BTN_LONG);

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting FSM: snapshots running time, edits H/M/S from key events,
// pulses load on commit, aborts on inactivity, and drives blink/field select.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TIMEOUT_S = 10,
  parameter int BLINK_HZ  = 2
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic [1:0] mode_code,
  input  logic [1:0] adj_code,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       load,
  output logic       set_active,
  output logic [1:0] field_sel,
  output logic       blink_on
);

  localparam int TO_CYC = CLK_HZ * TIMEOUT_S;
  localparam int TO_W   = $clog2(TO_CYC);
  localparam int BL_CYC = CLK_HZ / (2 * BLINK_HZ);
  localparam int BL_W   = $clog2(BL_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BL_CYC - 1);

  logic w_mode_short, w_mode_long, w_adj_short, w_adj_long;

  btn_event u_mode_ev (
    .i_clk      (CLOCK_50),
    .i_rst_n    (rst_n),
    .i_code     (mode_code),
    .o_short_ev (w_mode_short),
    .o_long_ev  (w_mode_long)
  );

  btn_event u_adj_ev (
    .i_clk      (CLOCK_50),
    .i_rst_n    (rst_n),
    .i_code     (adj_code),
    .o_short_ev (w_adj_short),
    .o_long_ev  (w_adj_long)
  );

  state_t          r_state, w_state_nxt;
  logic [4:0]      r_hour, w_hour_nxt;
  logic [5:0]      r_min, w_min_nxt;
  logic [5:0]      r_sec, w_sec_nxt;
  logic            r_load, w_load_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_nxt;
  logic [BL_W-1:0] r_bl_cnt, w_bl_nxt;
  logic            r_blink, w_blink_nxt;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_hour   <= '0;
      r_min    <= '0;
      r_sec    <= '0;
      r_load   <= 1'b0;
      r_to_cnt <= '0;
      r_bl_cnt <= '0;
      r_blink  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_hour   <= w_hour_nxt;
      r_min    <= w_min_nxt;
      r_sec    <= w_sec_nxt;
      r_load   <= w_load_nxt;
      r_to_cnt <= w_to_nxt;
      r_bl_cnt <= w_bl_nxt;
      r_blink  <= w_blink_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hour_nxt  = r_hour;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_load_nxt  = 1'b0;
    w_to_nxt    = r_to_cnt;
    w_bl_nxt    = r_bl_cnt;
    w_blink_nxt = r_blink;

    if (r_state == ST_RUN) begin
      // Holding the counters at their restart values makes set-state entry free.
      w_to_nxt    = '0;
      w_bl_nxt    = '0;
      w_blink_nxt = 1'b1;
      if (w_mode_long) begin
        w_state_nxt = ST_SET_H;
        w_hour_nxt  = cur_hour;
        w_min_nxt   = cur_min;
        w_sec_nxt   = cur_sec;
      end
    end else begin
      w_to_nxt = r_to_cnt + 1'b1;
      if (r_bl_cnt == BL_LAST) begin
        w_bl_nxt    = '0;
        w_blink_nxt = ~r_blink;
      end else begin
        w_bl_nxt = r_bl_cnt + 1'b1;
      end

      // Mode events take priority; a simultaneous adj event is dropped.
      if (w_mode_short) begin
        case (r_state)
          ST_SET_H: w_state_nxt = ST_SET_M;
          ST_SET_M: w_state_nxt = ST_SET_S;
          default:  w_state_nxt = ST_SET_H;
        endcase
        w_to_nxt    = '0;
        w_bl_nxt    = '0;
        w_blink_nxt = 1'b1;
      end else if (w_mode_long) begin
        w_load_nxt  = 1'b1;
        w_state_nxt = ST_RUN;
        w_to_nxt    = '0;
      end else if (w_adj_short || w_adj_long) begin
        if (r_state == ST_SET_H)
          w_hour_nxt = (w_adj_long || r_hour == HOUR_MAX) ? 5'd0 : r_hour + 5'd1;
        else if (r_state == ST_SET_M)
          w_min_nxt = (w_adj_long || r_min == MS_MAX) ? 6'd0 : r_min + 6'd1;
        else
          w_sec_nxt = (w_adj_long || r_sec == MS_MAX) ? 6'd0 : r_sec + 6'd1;
        w_to_nxt    = '0;
        w_bl_nxt    = '0;
        w_blink_nxt = 1'b1;
      end else if (r_to_cnt == TO_LAST) begin
        w_state_nxt = ST_RUN;
        w_to_nxt    = '0;
      end
    end
  end

  assign set_hour   = r_hour;
  assign set_min    = r_min;
  assign set_sec    = r_sec;
  assign load       = r_load;
  assign set_active = (r_state != ST_RUN);
  assign field_sel  = fsel_of(r_state);
  assign blink_on   = (r_state == ST_RUN) || r_blink;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized and directed bench for clock_set_ctrl against a behavioural model.
module tb_clock_set_ctrl;

  localparam int CLK_HZ = 100;
  localparam int TIMEOUT_S = 2;
  localparam int BLINK_HZ = 5;
  localparam int TO_CYC = CLK_HZ * TIMEOUT_S;
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);

  logic       CLOCK_50 = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode_code = 2'b00;
  logic [1:0] adj_code = 2'b00;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0;
  logic [5:0] cur_sec = '0;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       load;
  logic       set_active;
  logic [1:0] field_sel;
  logic       blink_on;

  clock_set_ctrl #(.CLK_HZ(CLK_HZ), .TIMEOUT_S(TIMEOUT_S), .BLINK_HZ(BLINK_HZ)) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .mode_code(mode_code), .adj_code(adj_code),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec), .load(load),
    .set_active(set_active), .field_sel(field_sel), .blink_on(blink_on)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: state 0=RUN 1=H 2=M 3=S; idle = cycles since last event; bj = cycles since blink restart.
  int m_state, m_h, m_m, m_s, m_load, m_idle, m_bj, m_pm, m_pa;

  task automatic mdl_reset();
    m_state = 0; m_h = 0; m_m = 0; m_s = 0; m_load = 0;
    m_idle = 0; m_bj = 0; m_pm = 0; m_pa = 0;
  endtask

  task automatic mdl_step();
    bit ms, ml, as, al;
    ms = (m_pm == 0) && (mode_code == 2'b01);
    ml = (m_pm == 0) && (mode_code == 2'b10);
    as = (m_pa == 0) && (adj_code == 2'b01);
    al = (m_pa == 0) && (adj_code == 2'b10);
    m_load = 0;
    if (m_state == 0) begin
      if (ml) begin
        m_state = 1; m_h = cur_hour; m_m = cur_min; m_s = cur_sec;
        m_idle = 0; m_bj = 0;
      end
    end else if (ms) begin
      m_state = (m_state == 3) ? 1 : m_state + 1;
      m_idle = 0; m_bj = 0;
    end else if (ml) begin
      m_load = 1; m_state = 0;
    end else if (as || al) begin
      case (m_state)
        1: m_h = al ? 0 : (m_h + 1) % 24;
        2: m_m = al ? 0 : (m_m + 1) % 60;
        default: m_s = al ? 0 : (m_s + 1) % 60;
      endcase
      m_idle = 0; m_bj = 0;
    end else if (m_idle == TO_CYC - 1) begin
      m_state = 0;
    end else begin
      m_idle++; m_bj++;
    end
    m_pm = mode_code;
    m_pa = adj_code;
  endtask

  function automatic logic [21:0] dut_vec();
    return {set_hour, set_min, set_sec, load, set_active, field_sel, blink_on};
  endfunction

  function automatic logic [21:0] mdl_vec();
    logic b;
    b = (m_state == 0) || (((m_bj / HALF) % 2) == 0);
    return {5'(m_h), 6'(m_m), 6'(m_s), 1'(m_load), (m_state != 0), 2'(m_state), b};
  endfunction

  task automatic cycle();
    if (rst_n) mdl_step();
    else mdl_reset();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press(input bit is_mode, input logic [1:0] code);
    if (is_mode) mode_code = code; else adj_code = code;
    cycle();
    if (is_mode) mode_code = 2'b00; else adj_code = 2'b00;
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 0;
    mdl_reset();
    #12;
    n_cmp++;
    if (dut_vec() !== 22'h1) begin
      n_bad++; $display("FAIL reset_state got %h exp %h", dut_vec(), 22'h1);
    end
    @(posedge CLOCK_50); #1;
    rst_n = 1;
    cycle();
    n_cmp++;
    if (dut_vec() !== mdl_vec()) begin
      n_bad++; $display("FAIL reset_release got %h exp %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_enter_set();
    logic [21:0] exp;
    cur_hour = 5'd13; cur_min = 6'd45; cur_sec = 6'd30;
    mode_code = 2'b10;
    cycle();
    exp = {5'd13, 6'd45, 6'd30, 1'b0, 1'b1, 2'b01, 1'b1};
    n_cmp++;
    if (dut_vec() !== exp) begin
      n_bad++; $display("FAIL enter_set got %h exp %h", dut_vec(), exp);
    end
    n_cmp++;
    if (dut_vec() !== mdl_vec()) begin
      n_bad++; $display("FAIL enter_set_model got %h exp %h", dut_vec(), mdl_vec());
    end
    mode_code = 2'b00;
    cycle();
  endtask

  task automatic test_incr_wrap();
    repeat (9) press(0, 2'b01);
    n_cmp++;
    if (dut_vec() !== mdl_vec()) begin
      n_bad++; $display("FAIL hour_to_22 got %h exp %h", dut_vec(), mdl_vec());
    end
    press(0, 2'b01);
    n_cmp++;
    if (set_hour !== 5'd23) begin
      n_bad++; $display("FAIL hour_23 got %0d exp 23", set_hour);
    end
    press(0, 2'b01);
    n_cmp++;
    if (set_hour !== 5'd0) begin
      n_bad++; $display("FAIL hour_wrap got %0d exp 0", set_hour);
    end
    press(1, 2'b01);
    repeat (14) press(0, 2'b01);
    n_cmp++;
    if (set_min !== 6'd59 || field_sel !== 2'b10) begin
      n_bad++; $display("FAIL min_59 got %0d/%0d exp 59/2", set_min, field_sel);
    end
    press(0, 2'b01);
    n_cmp++;
    if (set_min !== 6'd0) begin
      n_bad++; $display("FAIL min_wrap got %0d exp 0", set_min);
    end
  endtask

  task automatic test_clear_commit();
    repeat (3) press(0, 2'b01);
    press(0, 2'b10);
    n_cmp++;
    if (set_min !== 6'd0) begin
      n_bad++; $display("FAIL min_clear got %0d exp 0", set_min);
    end
    press(1, 2'b01);
    n_cmp++;
    if (field_sel !== 2'b11) begin
      n_bad++; $display("FAIL fsel_sec got %0d exp 3", field_sel);
    end
    mode_code = 2'b10;
    cycle();
    n_cmp++;
    if ({load, set_active, set_hour, set_min, set_sec} !== {1'b1, 1'b0, 5'd0, 6'd0, 6'd30}) begin
      n_bad++;
      $display("FAIL commit got load=%0d act=%0d %0d:%0d:%0d exp load=1 act=0 0:0:30",
               load, set_active, set_hour, set_min, set_sec);
    end
    mode_code = 2'b00;
    cycle();
    n_cmp++;
    if (load !== 1'b0 || set_active !== 1'b0) begin
      n_bad++; $display("FAIL load_pulse got load=%0d act=%0d exp 0/0", load, set_active);
    end
  endtask

  task automatic test_level_hold(output int h0);
    h0 = $urandom_range(1, 20);
    cur_hour = 5'(h0); cur_min = 6'($urandom_range(0, 59)); cur_sec = 6'($urandom_range(0, 59));
    press(1, 2'b10);
    adj_code = 2'b01;
    repeat (50) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL hold_cycle got %h exp %h", dut_vec(), mdl_vec());
      end
    end
    adj_code = 2'b00;
    cycle();
    n_cmp++;
    if (set_hour !== 5'((h0 + 1) % 24)) begin
      n_bad++; $display("FAIL hold_once got %0d exp %0d", set_hour, (h0 + 1) % 24);
    end
    adj_code = 2'b11;
    repeat (5) cycle();
    adj_code = 2'b00;
    cycle();
    adj_code = 2'b01;
    cycle();
    adj_code = 2'b10;
    cycle();
    adj_code = 2'b00;
    cycle();
    n_cmp++;
    if (set_hour !== 5'((h0 + 2) % 24)) begin
      n_bad++; $display("FAIL code11_direct got %0d exp %0d", set_hour, (h0 + 2) % 24);
    end
  endtask

  task automatic test_simultaneous(input int h0);
    mode_code = 2'b01; adj_code = 2'b01;
    cycle();
    n_cmp++;
    if (field_sel !== 2'b10 || set_hour !== 5'((h0 + 2) % 24)) begin
      n_bad++;
      $display("FAIL simultaneous got fsel=%0d hour=%0d exp fsel=2 hour=%0d",
               field_sel, set_hour, (h0 + 2) % 24);
    end
    mode_code = 2'b00; adj_code = 2'b00;
    cycle();
  endtask

  task automatic test_timeout();
    int active_cnt, load_cnt;
    active_cnt = 0; load_cnt = 0;
    adj_code = 2'b10;
    cycle();
    adj_code = 2'b00;
    repeat (TO_CYC - 1) begin
      cycle();
      if (set_active === 1'b1) active_cnt++;
      if (load !== 1'b0) load_cnt++;
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL timeout_cycle got %h exp %h", dut_vec(), mdl_vec());
      end
    end
    n_cmp++;
    if (active_cnt !== TO_CYC - 1) begin
      n_bad++; $display("FAIL timeout_early got %0d active cycles exp %0d", active_cnt, TO_CYC - 1);
    end
    cycle();
    if (load !== 1'b0) load_cnt++;
    n_cmp++;
    if (set_active !== 1'b0 || load_cnt !== 0) begin
      n_bad++; $display("FAIL timeout_abort got act=%0d loads=%0d exp 0/0", set_active, load_cnt);
    end
  endtask

  task automatic test_reset_mid();
    press(1, 2'b10);
    press(1, 2'b01);
    #2;
    rst_n = 0;
    mdl_reset();
    #1;
    n_cmp++;
    if (dut_vec() !== 22'h1) begin
      n_bad++; $display("FAIL async_reset got %h exp %h", dut_vec(), 22'h1);
    end
    @(posedge CLOCK_50); #1;
    rst_n = 1;
    cycle();
    n_cmp++;
    if (dut_vec() !== mdl_vec()) begin
      n_bad++; $display("FAIL post_reset got %h exp %h", dut_vec(), mdl_vec());
    end
  endtask

  function automatic logic [1:0] pick(input logic [1:0] cur);
    int r;
    r = $urandom_range(0, 15);
    if (r < 8) return cur;
    if (r < 12) return 2'b00;
    if (r < 14) return 2'b01;
    if (r < 15) return 2'b10;
    return 2'b11;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      mode_code = pick(mode_code);
      adj_code = pick(adj_code);
      cur_hour = 5'($urandom_range(0, 23));
      cur_min = 6'($urandom_range(0, 59));
      cur_sec = 6'($urandom_range(0, 59));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 0;
        mdl_reset();
      end else begin
        rst_n = 1;
      end
      cycle();
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL random_%0d got %h exp %h", i, dut_vec(), mdl_vec());
      end
    end
    rst_n = 1;
  endtask

  initial begin
    int h0;
    mdl_reset();
    test_reset();
    test_enter_set();
    test_incr_wrap();
    test_clear_commit();
    test_level_hold(h0);
    test_simultaneous(h0);
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
